// File: rtl/riscv_id_ex_stage_pkg.sv
// Shared definitions for the RV32I decode/issue stage: ALU opcode codes,
// major-opcode and funct7 constants, and the issue entry carried by the skid buffer.
package riscv_id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD          = 4'd0;
    localparam logic [3:0] ALU_SUB          = 4'd1;
    localparam logic [3:0] ALU_AND          = 4'd2;
    localparam logic [3:0] ALU_OR           = 4'd3;
    localparam logic [3:0] ALU_XOR          = 4'd4;
    localparam logic [3:0] ALU_SHIFTL       = 4'd5;
    localparam logic [3:0] ALU_SHIFTR       = 4'd6;
    localparam logic [3:0] ALU_SHIFTR_ARITH = 4'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } issue_t;

    localparam issue_t ISSUE_RESET = '{op: ALU_ADD, a: 32'd0, b: 32'd0, rd: 5'd0,
                                       rd_we: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC into ALU opcode,
// operands and writeback control; anything else is flagged illegal with zeroed operands.
module riscv_alu_decode
    import riscv_id_ex_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [3:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        legal;
    logic [3:0]  op_sel;
    logic [31:0] a_sel;
    logic [31:0] b_sel;
    logic        unused_rs1_idx;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};
    // Register indices were already used by the register file read upstream.
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        legal  = 1'b0;
        op_sel = ALU_ADD;
        a_sel  = rs1_data;
        b_sel  = rs2_data;
        unique case (opcode)
            OPC_OP: begin
                case (f3)
                    3'b000: begin
                        legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
                        op_sel = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b100: begin legal = (f7 == F7_BASE); op_sel = ALU_XOR; end
                    3'b110: begin legal = (f7 == F7_BASE); op_sel = ALU_OR; end
                    3'b111: begin legal = (f7 == F7_BASE); op_sel = ALU_AND; end
                    3'b001: begin legal = (f7 == F7_BASE); op_sel = ALU_SHIFTL; end
                    3'b101: begin
                        legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
                        op_sel = (f7 == F7_ALT) ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                b_sel = imm_i;
                case (f3)
                    3'b000: begin legal = 1'b1; op_sel = ALU_ADD; end
                    3'b100: begin legal = 1'b1; op_sel = ALU_XOR; end
                    3'b110: begin legal = 1'b1; op_sel = ALU_OR; end
                    3'b111: begin legal = 1'b1; op_sel = ALU_AND; end
                    3'b001: begin
                        legal  = (f7 == F7_BASE);
                        op_sel = ALU_SHIFTL;
                        b_sel  = shamt;
                    end
                    3'b101: begin
                        legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
                        op_sel = (f7 == F7_ALT) ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
                        b_sel  = shamt;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                a_sel = 32'd0;
                b_sel = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a_sel = pc;
                b_sel = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    assign op      = legal ? op_sel : ALU_ADD;
    assign a       = legal ? a_sel : 32'd0;
    assign b       = legal ? b_sel : 32'd0;
    assign rd      = instr[11:7];
    assign rd_we   = legal && (instr[11:7] != 5'd0);
    assign illegal = ~legal;

endmodule

// File: rtl/riscv_id_ex_stage.sv
// Decode/issue stage in front of riscv_alu: decoded entries pass through a
// 2-entry skid buffer so out_ready never reaches in_ready combinationally.
module riscv_id_ex_stage
    import riscv_id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    issue_t dec;
    issue_t main_d, main_q;
    issue_t skid_d, skid_q;
    logic   main_valid_d, main_valid_q;
    logic   skid_valid_d, skid_valid_q;
    logic   in_ready_d, in_ready_q;
    logic   accept;

    riscv_alu_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .op       (dec.op),
        .a        (dec.a),
        .b        (dec.b),
        .rd       (dec.rd),
        .rd_we    (dec.rd_we),
        .illegal  (dec.illegal)
    );

    assign accept = in_valid && in_ready_q && !flush;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            // Main is free this edge: the older skid entry has priority over a new one.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = dec;
                end
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= ISSUE_RESET;
            skid_q       <= ISSUE_RESET;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_alu_op  = main_q.op;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_rd      = main_q.rd;
    assign out_rd_we   = main_q.rd_we;
    assign out_illegal = main_q.illegal;

endmodule
